// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Load/store unit of the MIPS datapath. This unit accepts one memory operation
// at a time from the execute stage. It drives a word-wide data memory through a
// req/ack handshake. It steers byte and half-word lanes (little-endian: lane i
// is addr[1:0] == i) and sign- or zero-extends loads. The aligned 32-bit load
// result goes to the write-back selector.
//
// Parameters
//   TIMEOUT  cycles mem_req may stay high without mem_ack before the access
//            aborts with a timeout error (minimum 2)
//   ADDR_W   byte-address width
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   req_valid     execute stage presents an operation this cycle
//   mem_read      operation is a load
//   mem_write     operation is a store
//   size          00 byte, 01 half, 10 word, 11 reserved
//   is_unsigned   loads: zero-extend when 1, sign-extend when 0
//   addr          byte address
//   wdata         store data (low bits significant for byte/half)
//   busy          unit occupied; upstream holds and stalls
//   done          one-cycle pulse on successful completion
//   rdata         extended load result, held until the next successful load
//   err           one-cycle pulse on rejection or abort
//   err_code      01 misaligned, 10 illegal, 11 timeout; held until next err
//   mem_req       memory request
//   mem_we        memory write enable
//   mem_addr      word address (addr with bits [1:0] cleared)
//   mem_be        byte enables, bit i covers data bits [8i+7:8i]
//   mem_wdata     lane-replicated store data
//   mem_ack       memory accepted the write / returned read data
//   mem_rdata     memory read word, valid with mem_ack
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_DONE   = 2'b10,
        S_ERR    = 2'b11
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] EC_MISALIGN = 2'b01;
    localparam logic [1:0] EC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EC_TIMEOUT  = 2'b11;

    // The counter only has to reach TIMEOUT-1.
    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;

    // Request fields latched at acceptance, used when the load data returns.
    logic             we_q;
    logic             uns_q;
    logic [1:0]       size_q;
    logic [1:0]       lane_q;

    // Request decode. This decode is only meaningful while IDLE.
    logic             op_req;
    logic             illegal;
    logic             misaligned;
    logic             accept;
    logic             cnt_expired;

    // -------------------------------------------------------------------------
    // Lane helpers
    // -------------------------------------------------------------------------
    function automatic logic [3:0] lane_enables(input logic [1:0] sz,
                                                input logic [1:0] lane);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = 4'b0011 << lane;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // The store data is replicated across lanes so that the byte enables alone
    // select what the memory writes. No separate shift is needed.
    function automatic logic [31:0] lane_replicate(input logic [1:0]  sz,
                                                   input logic [31:0] data);
        logic [31:0] rep;
        case (sz)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  lane,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = 8'(word >> {lane, 3'b000});
        h = 16'(word >> {lane, 3'b000});
        case (sz)
            SZ_BYTE: res = {{24{b[7] & ~uns}}, b};
            SZ_HALF: res = {{16{h[15] & ~uns}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Request classification
    // -------------------------------------------------------------------------
    always_comb begin
        op_req      = req_valid & (mem_read | mem_write);
        illegal     = (mem_read & mem_write) | (size == 2'b11);
        misaligned  = ((size == SZ_HALF) & addr[0]) |
                      ((size == SZ_WORD) & (addr[1:0] != 2'b00));
        accept      = op_req & ~illegal & ~misaligned;
        // The acknowledge has priority on the final cycle.
        cnt_expired = (wait_cnt == CNT_LAST) & ~mem_ack;
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches on paths that do not change state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (op_req) begin
                    state_nxt = accept ? S_ACCESS : S_ERR;
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_nxt = S_DONE;
                end else if (cnt_expired) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // These outputs are decoded from the state register alone. For that reason
    // an asynchronous reset drops mem_req and busy right away.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        case (state)
            S_IDLE: ;
            S_ACCESS: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = we_q;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            S_ERR: begin
                busy = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: request latch, memory-side registers, timeout counter, results
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            size_q    <= 2'b00;
            lane_q    <= 2'b00;
            wait_cnt  <= '0;
            rdata     <= 32'h0;
            err_code  <= 2'b00;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        we_q      <= mem_write;
                        uns_q     <= is_unsigned;
                        size_q    <= size;
                        lane_q    <= addr[1:0];
                        wait_cnt  <= '0;
                        mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        mem_be    <= lane_enables(size, addr[1:0]);
                        mem_wdata <= lane_replicate(size, wdata);
                    end else if (op_req) begin
                        // The illegal check takes precedence over misalignment.
                        err_code <= illegal ? EC_ILLEGAL : EC_MISALIGN;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        if (!we_q) begin
                            rdata <= load_extend(mem_rdata, size_q, lane_q, uns_q);
                        end
                    end else if (cnt_expired) begin
                        err_code <= EC_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit of the MIPS datapath, sitting directly upstream of the write-back data selector.
- Accepts one memory operation at a time from the execute stage and drives a word-wide data memory through a req/ack handshake.
- Performs byte/half/word lane steering and sign/zero extension.
- Presents the aligned 32-bit load result that the write-back mux selects against the ALU result.

Parameters:
- TIMEOUT, 16, cycles mem_req may stay high without mem_ack before the access aborts with an error (minimum 2).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  execute stage presents an operation this cycle.
- mem_read  in  1  operation is a load.
- mem_write  in  1  operation is a store.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- is_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data; low bits are significant for byte/half.
- busy  out  1  unit is occupied; upstream must hold and stall.
- done  out  1  one-cycle pulse: operation completed successfully.
- rdata  out  32  extended load result; held until the next successful load.
- err  out  1  one-cycle pulse: operation rejected or aborted.
- err_code  out  2  01 misaligned, 10 illegal (rd&wr both set, or size 11), 11 timeout; held until the next err.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word address; addr with bits [1:0] forced to 0.
- mem_be  out  4  byte enables; bit i enables data bits [8i+7:8i].
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory accepted the write or returned read data.
- mem_rdata  in  32  memory read word, valid when mem_ack is high.

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - busy, done, err, mem_req and mem_we go to 0.
  - rdata, err_code, mem_addr, mem_be and mem_wdata go to 0.
  - Timeout counter clears.
  - A reset during ACCESS drops mem_req at once; the pending operation is discarded.
- Byte lanes are little-endian: lane i is addr[1:0] == i.
- FSM states: IDLE, ACCESS, DONE, ERR. busy = (state != IDLE).
- IDLE:
  - req_valid with neither mem_read nor mem_write: no-op, stay in IDLE.
  - Illegal request (both mem_read and mem_write, or size 11): go to ERR with code 10.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0): go to ERR with code 01.
  - Valid request: latch all request fields and go to ACCESS.
  - No memory access is ever issued for an illegal or misaligned request.
- ACCESS:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata are registered and stable until ack.
  - mem_be: byte = 0001<<lane; half = 0011<<lane; word = 1111.
  - mem_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
  - Counter increments each cycle mem_ack is low.
  - mem_ack=1: a load captures the extracted and extended lane into rdata; then go to DONE. This holds even on the cycle the counter reaches its limit (ack wins).
  - Counter reaches TIMEOUT-1 with no ack: go to ERR with code 11.
- DONE: done=1 for exactly one cycle, mem_req=0, then IDLE. Stores leave rdata unchanged.
- ERR: err=1 for exactly one cycle, err_code updated, then IDLE.
- Requests are ignored while busy; upstream holds them.
- Latency:
  - Request sampled at edge 0; mem_req high in cycle 1.
  - Ack in cycle k (k >= 1) gives done in cycle k+1; a zero-wait memory gives done 2 cycles after acceptance.
  - Rejected requests give err in the cycle after acceptance.
  - Back-to-back throughput: one operation per (wait + 3) cycles.
- Load extension:
  - Byte: bits [8*lane+7 : 8*lane], sign bit is bit 7.
  - Half: bits [8*lane+15 : 8*lane], sign bit is bit 15.
  - Word: passthrough.

Test Plan:
- Word load at 0x100, mem_rdata=0xDEADBEEF, ack in first ACCESS cycle -> mem_addr=0x100, mem_be=1111, done 2 cycles after request, rdata=0xDEADBEEF.
- Signed byte load at 0x103, then unsigned byte load at 0x103, mem_rdata=0x80FF_0000 -> mem_be=1000; rdata=0xFFFFFF80, then 0x00000080.
- Half store at 0x202, wdata=0x1234ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; rdata unchanged.
- Word load at 0x101, then request with mem_read=mem_write=1 -> mem_req never rises; err pulses with code 01, then code 10.
- TIMEOUT=16, ack never arrives -> mem_req high 16 cycles, then err with code 11, busy falls. Repeat with ack on the 16th cycle -> done instead of err.
- rst_n low in the 3rd ACCESS cycle -> mem_req and busy drop immediately; after release a new word load completes normally.
